// File: rtl/perceptron_mac_if.sv
// Element/result bundle for perceptron_mac: signed operand stream with vector
// framing and abort going in, completed dot products coming out.
interface perceptron_mac_if #(
    parameter int A_W   = 32,
    parameter int B_W   = 32,
    parameter int ACC_W = 64
);
    logic                    CLR;
    logic                    IN_VALID;
    logic                    IN_LAST;
    logic signed [A_W-1:0]   A;
    logic signed [B_W-1:0]   B;
    logic                    OUT_VALID;
    logic signed [ACC_W-1:0] ACC;

    modport master (
        output CLR, IN_VALID, IN_LAST, A, B,
        input  OUT_VALID, ACC
    );

    modport slave (
        input  CLR, IN_VALID, IN_LAST, A, B,
        output OUT_VALID, ACC
    );
endinterface

// File: rtl/perceptron_mac.sv
// Streaming signed dot-product engine: operand register, PIPE multiplier stages,
// FIRST/ACCUM accumulator. Define MAC_SATURATE_EN for saturating accumulation.
module perceptron_mac #(
    parameter int A_W   = 32,
    parameter int B_W   = 32,
    parameter int ACC_W = 64,   // must be >= A_W + B_W
    parameter int PIPE  = 2     // 1..4
) (
    input  logic            CLK,
    input  logic            RESETN,
    perceptron_mac_if.slave mac
);
    localparam int P_W = A_W + B_W;

    typedef enum logic {S_FIRST, S_ACCUM} state_t;

    logic signed [A_W-1:0]   a_q;
    logic signed [B_W-1:0]   b_q;
    logic [PIPE:0]           vld_q;
    logic [PIPE:0]           lst_q;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum_d;
    logic signed [ACC_W-1:0] sum_q;
    logic signed [ACC_W-1:0] acc_q;
    logic                    out_valid_q;
    state_t                  state_q;

    // Operand data is only meaningful where the valid chain says so.
    always_ff @(posedge CLK) begin
        if (mac.IN_VALID) begin
            a_q <= mac.A;
            b_q <= mac.B;
        end
    end

    // Bit k of the valid/last chains travels alongside multiplier stage k.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            vld_q <= '0;
            lst_q <= '0;
        end else if (mac.CLR) begin
            vld_q <= '0;
            lst_q <= '0;
        end else begin
            vld_q <= {vld_q[PIPE-1:0], mac.IN_VALID};
            lst_q <= {lst_q[PIPE-1:0], mac.IN_VALID & mac.IN_LAST};
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi <= PIPE; gi++) begin : g_stage
            logic signed [P_W-1:0] p_q;
            if (gi == 1) begin : g_mul
                always_ff @(posedge CLK) begin
                    p_q <= P_W'(a_q) * P_W'(b_q);
                end
            end else begin : g_shift
                always_ff @(posedge CLK) begin
                    p_q <= g_stage[gi-1].p_q;
                end
            end
        end
    endgenerate

    assign prod_ext = ACC_W'(g_stage[PIPE].p_q);

`ifdef MAC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] sum_wide;

    // One guard bit exposes signed overflow: the top two bits then disagree.
    always_comb begin
        sum_wide = {sum_q[ACC_W-1], sum_q} + {prod_ext[ACC_W-1], prod_ext};
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            sum_d = sum_wide[ACC_W] ? SAT_MIN : SAT_MAX;
        end else begin
            sum_d = sum_wide[ACC_W-1:0];
        end
    end
`else
    assign sum_d = sum_q + prod_ext;
`endif

    // ACC only moves when a vector completes, so partial sums never show.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= S_FIRST;
            sum_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (mac.CLR) begin
                state_q <= S_FIRST;
                sum_q   <= '0;
            end else if (vld_q[PIPE]) begin
                case (state_q)
                    S_FIRST: begin
                        sum_q <= prod_ext;
                        if (lst_q[PIPE]) begin
                            acc_q       <= prod_ext;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_ACCUM;
                        end
                    end
                    S_ACCUM: begin
                        sum_q <= sum_d;
                        if (lst_q[PIPE]) begin
                            acc_q       <= sum_d;
                            out_valid_q <= 1'b1;
                            state_q     <= S_FIRST;
                        end
                    end
                    default: state_q <= S_FIRST;
                endcase
            end
        end
    end

    assign mac.OUT_VALID = out_valid_q;
    assign mac.ACC       = acc_q;
endmodule

// File: tb/tb_perceptron_mac.sv
// Directed bench for perceptron_mac: default 64-bit instance driven from a
// vector table with a scoreboard monitor, plus a 16x16/32 instance for overflow.
`timescale 1ns/1ps
module tb_perceptron_mac;
    localparam int PIPE2 = 3;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    perceptron_mac_if #(.A_W(32), .B_W(32), .ACC_W(64)) bus ();
    perceptron_mac_if #(.A_W(16), .B_W(16), .ACC_W(32)) bus16 ();

    perceptron_mac #(.A_W(32), .B_W(32), .ACC_W(64), .PIPE(2)) dut (
        .CLK(clk), .RESETN(resetn), .mac(bus)
    );
    perceptron_mac #(.A_W(16), .B_W(16), .ACC_W(32), .PIPE(PIPE2)) dut16 (
        .CLK(clk), .RESETN(resetn), .mac(bus16)
    );

    typedef struct {
        logic signed [31:0] a;
        logic signed [31:0] b;
        bit                 last;
        int                 gap;
        logic signed [63:0] exp_acc;
    } vec_t;

    typedef struct {
        logic signed [63:0] acc;
        int                 cyc;
    } exp_t;

    int                 total = 0;
    int                 bad = 0;
    int                 edge_n = 0;
    bit                 mon_en = 1'b0;
    logic signed [63:0] acc_hold = '0;
    exp_t               sb[$];

    always @(posedge clk) edge_n++;

    task automatic check(input string name, input logic signed [63:0] got,
                         input logic signed [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Every pulse must match the scoreboard head, including its edge number;
    // between pulses ACC must hold the last completed result.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!resetn) begin
                check("rst_out_valid", bus.OUT_VALID, 0);
                check("rst_acc", bus.ACC, 0);
                acc_hold = '0;
            end else if (bus.OUT_VALID) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out_valid: got pulse with ACC %0d, expected none", bus.ACC);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("acc", bus.ACC, e.acc);
                    check("latency_edge", edge_n, e.cyc);
                    acc_hold = e.acc;
                end
            end else begin
                check("acc_hold", bus.ACC, acc_hold);
            end
        end
    end

    task automatic drive(input logic signed [31:0] a, input logic signed [31:0] b,
                         input bit last, input int gap, input logic signed [63:0] exp_acc);
        @(negedge clk);
        bus.CLR      = 1'b0;
        bus.IN_VALID = 1'b1;
        bus.A        = a;
        bus.B        = b;
        bus.IN_LAST  = last;
        if (last) begin
            exp_t e;
            e.acc = exp_acc;
            e.cyc = edge_n + 1 + 3;
            sb.push_back(e);
        end
        $display("elem a=%0d b=%0d last=%0d gap=%0d", a, b, last, gap);
        repeat (gap) begin
            @(negedge clk);
            bus.IN_VALID = 1'b0;
            bus.IN_LAST  = 1'($urandom);
            bus.A        = $urandom;
            bus.B        = $urandom;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.IN_VALID = 1'b0;
        bus.IN_LAST  = 1'b0;
        bus.CLR      = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t               tbl[11];
        int                 t16;
        bit                 seen;
        logic signed [63:0] exp16;

        tbl[0]  = '{32'sd7456, 32'sd1525, 1'b1, 0, 64'sd11370400};
        tbl[1]  = '{-32'sd1145, -32'sd9243, 1'b1, 0, 64'sd10583235};
        tbl[2]  = '{32'sd1872, 32'sd6723, 1'b1, 0, 64'sd12585456};
        tbl[3]  = '{32'sd7456, 32'sd1525, 1'b0, 0, 64'sd0};
        tbl[4]  = '{-32'sd1145, -32'sd9243, 1'b0, 0, 64'sd0};
        tbl[5]  = '{32'sd1872, 32'sd6723, 1'b1, 0, 64'sd34539091};
        tbl[6]  = '{-32'sd7456, 32'sd1525, 1'b0, 2, 64'sd0};
        tbl[7]  = '{32'sd0, 32'sd5, 1'b0, 2, 64'sd0};
        tbl[8]  = '{32'sd47425, 32'sd963, 1'b1, 2, 64'sd34299875};
        tbl[9]  = '{32'sh8000_0000, 32'sh8000_0000, 1'b0, 0, 64'sd0};
`ifdef MAC_SATURATE_EN
        tbl[10] = '{32'sh8000_0000, 32'sh8000_0000, 1'b1, 0, 64'sh7FFF_FFFF_FFFF_FFFF};
        exp16   = 64'sd2147483647;
`else
        tbl[10] = '{32'sh8000_0000, 32'sh8000_0000, 1'b1, 0, 64'sh8000_0000_0000_0000};
        exp16   = -64'sd262140;
`endif

        resetn         = 1'b1;
        bus.CLR        = 1'b0;
        bus.IN_VALID   = 1'b0;
        bus.IN_LAST    = 1'b0;
        bus.A          = '0;
        bus.B          = '0;
        bus16.CLR      = 1'b0;
        bus16.IN_VALID = 1'b0;
        bus16.IN_LAST  = 1'b0;
        bus16.A        = '0;
        bus16.B        = '0;

        #3 resetn = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].last, tbl[i].gap, tbl[i].exp_acc);
        end
        idle(8);
        check("table_drained", sb.size(), 0);

        // Abort a partial vector; the element offered with CLR must vanish.
        drive(32'sd19987, 32'sd253, 1'b0, 0, 64'sd0);
        drive(32'sd5, 32'sd5, 1'b0, 0, 64'sd0);
        @(negedge clk);
        bus.CLR      = 1'b1;
        bus.IN_VALID = 1'b1;
        bus.IN_LAST  = 1'b1;
        bus.A        = 32'sd1000;
        bus.B        = 32'sd1000;
        $display("clr with element a=1000 b=1000 last=1");
        drive(32'sd1872, 32'sd6723, 1'b1, 0, 64'sd12585456);
        idle(8);
        check("clr_drained", sb.size(), 0);

        // Same partial vector, discarded by an asynchronous reset instead.
        drive(32'sd19987, 32'sd253, 1'b0, 0, 64'sd0);
        drive(32'sd5, 32'sd5, 1'b0, 0, 64'sd0);
        @(negedge clk);
        bus.IN_VALID = 1'b0;
        bus.IN_LAST  = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check("async_rst_acc", bus.ACC, 0);
        check("async_rst_out_valid", bus.OUT_VALID, 0);
        $display("reset pulse mid-vector");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        drive(32'sd1872, 32'sd6723, 1'b1, 0, 64'sd12585456);
        idle(8);
        check("rst_drained", sb.size(), 0);

        // Narrow instance: four max-positive products overflow 32 bits.
        check("acc16_reset", bus16.ACC, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus16.IN_VALID = 1'b1;
            bus16.A        = 16'sd32767;
            bus16.B        = 16'sd32767;
            bus16.IN_LAST  = (k == 3);
        end
        t16 = edge_n + 1;
        @(negedge clk);
        bus16.IN_VALID = 1'b0;
        bus16.IN_LAST  = 1'b0;
        seen = 1'b0;
        for (int w = 0; w < 12 && !seen; w++) begin
            if (bus16.OUT_VALID) seen = 1'b1;
            else @(negedge clk);
        end
        check("acc16_seen", seen, 1);
        check("acc16_latency_edge", edge_n, t16 + PIPE2 + 1);
        check("acc16", bus16.ACC, exp16);
        $display("narrow vector 4x(32767,32767) acc=%0d", bus16.ACC);
        @(negedge clk);
        check("acc16_pulse_width", bus16.OUT_VALID, 0);
        check("acc16_hold", bus16.ACC, exp16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
